// File: rtl/if_stage_pkg.sv
// Shared definitions for the fetch stage and its neighbours.
//   OP_HALT / OP_J : major opcodes (instr[31:26]); ID_stage decodes the same values
//   NOP_INSTR      : word placed in IF/ID on squash or reset
//   if_state_e     : fetch state machine encoding
//   is_halt()      : true when an instruction word carries the HALT opcode
package if_stage_pkg;

  localparam logic [5:0]  OP_HALT   = 6'b111111;
  localparam logic [5:0]  OP_J      = 6'b000010;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic {
    ST_FETCH  = 1'b0,
    ST_HALTED = 1'b1
  } if_state_e;

  function automatic logic is_halt(input logic [31:0] instr);
    return instr[31:26] == OP_HALT;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
//   clk, rst      : clock, synchronous active-high reset
//   hold_i        : keep all contents (ID stall)
//   flush_i       : replace instruction with NOP and drop valid (wrong-path squash)
//   load_i        : capture a fetched instruction with its PC and PC+4
//   instr_i/pc_i/pc_plus4_i : data captured on load
//   instr_o/pc_o/pc_plus4_o/valid_o : contents presented to ID
// Priority is rst > flush > hold > load; an edge with none of them
// inserts a bubble by clearing valid while leaving the data fields alone.
module if_id_reg #(
  parameter logic [31:0] NOP_VAL = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold_i,
  input  logic        flush_i,
  input  logic        load_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] pc_plus4_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        valid_o
);

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_o    <= NOP_VAL;
      pc_o       <= 32'h0000_0000;
      pc_plus4_o <= 32'h0000_0000;
      valid_o    <= 1'b0;
    end else if (flush_i) begin
      instr_o <= NOP_VAL;
      valid_o <= 1'b0;
    end else if (hold_i) begin
      // contents frozen while ID is stalled
    end else if (load_i) begin
      instr_o    <= instr_i;
      pc_o       <= pc_i;
      pc_plus4_o <= pc_plus4_i;
      valid_o    <= 1'b1;
    end else begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage.
//   clk, rst          : clock, synchronous active-high reset
//   stall             : ID hazard stall; hold PC and IF/ID, issue no request
//   redirect_en/_pc   : taken jump/branch; PC is reloaded, in-flight fetch squashed
//   imem_req/_addr    : fetch request and address (address is the current PC)
//   imem_ready/_rdata : memory accept and same-cycle instruction word
//   instruction, pc_out, pc_plus4, if_valid : IF/ID contents for ID
//   halted            : a HALT has been fetched; no further requests until reset
module if_stage #(
  parameter logic [31:0] PC_RESET  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = if_stage_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic        if_valid,
  output logic        halted
);
  import if_stage_pkg::*;

  if_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        halted_q, halted_d;
  logic        accept;
  logic        redirect_take;
  logic [31:0] pc_inc;

  assign imem_req      = (state_q == ST_FETCH) & ~stall & ~rst;
  assign imem_addr     = pc_q;
  assign accept        = imem_req & imem_ready;
  // Once halted, the pipeline is draining: a late redirect must not restart fetch.
  assign redirect_take = redirect_en & (state_q == ST_FETCH);
  assign pc_inc        = pc_q + 32'd4;  // wraps modulo 2^32
  assign halted        = halted_q;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    halted_d = halted_q;
    if (redirect_take) begin
      pc_d = redirect_pc & ~32'd3;
    end else if (accept) begin
      if (is_halt(imem_rdata)) begin
        // PC parks on the HALT so the address stays meaningful for debug.
        state_d  = ST_HALTED;
        halted_d = 1'b1;
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_FETCH;
      pc_q     <= PC_RESET;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      halted_q <= halted_d;
    end
  end

  // Redirect overrides stall, so flush is presented with higher priority than hold.
  if_id_reg #(
    .NOP_VAL(NOP_INSTR)
  ) u_if_id_reg (
    .clk        (clk),
    .rst        (rst),
    .hold_i     (stall),
    .flush_i    (redirect_take),
    .load_i     (accept),
    .instr_i    (imem_rdata),
    .pc_i       (pc_q),
    .pc_plus4_i (pc_inc),
    .instr_o    (instruction),
    .pc_o       (pc_out),
    .pc_plus4_o (pc_plus4),
    .valid_o    (if_valid)
  );

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        if_valid;
  logic        halted;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] p4;
  } exp_t;
  exp_t exp_q[$];

  localparam logic [31:0] NOP  = 32'h0000_0000;
  localparam logic [31:0] W0   = 32'h2001_0001;
  localparam logic [31:0] W1   = 32'h2002_0002;
  localparam logic [31:0] W2   = 32'h2003_0003;
  localparam logic [31:0] W3   = 32'h0800_0010;
  localparam logic [31:0] W4   = 32'h8C44_0004;
  localparam logic [31:0] W2B  = 32'hAC55_0008;
  localparam logic [31:0] W5   = 32'h1234_5678;
  localparam logic [31:0] HALT = 32'hFC00_0000;

  if_stage #(
    .PC_RESET (32'h0000_0000),
    .NOP_INSTR(32'h0000_0000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .redirect_en(redirect_en),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .instruction(instruction),
    .pc_out     (pc_out),
    .pc_plus4   (pc_plus4),
    .if_valid   (if_valid),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle: drive inputs, check the combinational request, optionally
  // record the IF/ID contents expected after the coming edge.
  task automatic cyc(input logic s, input logic re, input logic [31:0] rpc,
                     input logic rdy, input logic [31:0] rd,
                     input logic ereq, input logic [31:0] eaddr,
                     input logic push, input logic [31:0] einstr, input logic [31:0] epc);
    exp_t e;
    stall       = s;
    redirect_en = re;
    redirect_pc = rpc;
    imem_ready  = rdy;
    imem_rdata  = rd;
    #1;
    chk("imem_req", {31'd0, imem_req}, {31'd0, ereq});
    chk("imem_addr", imem_addr, eaddr);
    if (push) begin
      e.instr = einstr;
      e.pc    = epc;
      e.p4    = epc + 32'd4;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state();
    chk("rst_instruction", instruction, NOP);
    chk("rst_pc_out", pc_out, 32'h0);
    chk("rst_pc_plus4", pc_plus4, 32'h0);
    chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_imem_addr", imem_addr, 32'h0);
  endtask

  // Scoreboard monitor: every cycle IF/ID is valid must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && if_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL ifid_unexpected: got instr=%h pc=%h with no expected entry", instruction, pc_out);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("txn instr=%h pc=%h pc4=%h", instruction, pc_out, pc_plus4);
        if (instruction !== e.instr || pc_out !== e.pc || pc_plus4 !== e.p4) begin
          errors++;
          $display("FAIL ifid_contents: got instr=%h pc=%h pc4=%h expected instr=%h pc=%h pc4=%h",
                   instruction, pc_out, pc_plus4, e.instr, e.pc, e.p4);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_en = 1'b0; redirect_pc = 32'h0;
    imem_ready = 1'b0; imem_rdata = 32'h0;
    #1;
    chk("req_in_reset", {31'd0, imem_req}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state();
    rst = 1'b0;

    // Straight-line fetch, then a 3-cycle stall holding W1/4
    cyc(0, 0, 32'h0, 1, W0, 1, 32'h0, 1, W0, 32'h0);
    cyc(0, 0, 32'h0, 1, W1, 1, 32'h4, 1, W1, 32'h4);
    repeat (3) cyc(1, 0, 32'h0, 1, 32'hDEAD_BEEF, 0, 32'h8, 1, W1, 32'h4);
    cyc(0, 0, 32'h0, 1, W2, 1, 32'h8, 1, W2, 32'h8);

    // Redirect squashes the concurrent accept at 12
    cyc(0, 1, 32'h0000_0042, 1, W3, 1, 32'hC, 0, NOP, 32'h0);
    chk("redir_instruction", instruction, NOP);
    chk("redir_if_valid", {31'd0, if_valid}, 32'd0);
    cyc(0, 0, 32'h0, 1, W4, 1, 32'h40, 1, W4, 32'h40);
    // Redirect wins over stall
    cyc(1, 1, 32'h0000_0083, 1, W3, 0, 32'h44, 0, NOP, 32'h0);
    chk("redir_stall_instruction", instruction, NOP);
    chk("redir_stall_if_valid", {31'd0, if_valid}, 32'd0);

    // Memory not ready at addr 8 for two cycles
    cyc(0, 1, 32'h0000_0008, 1, W3, 1, 32'h80, 0, NOP, 32'h0);
    repeat (2) begin
      cyc(0, 0, 32'h0, 0, W3, 1, 32'h8, 0, NOP, 32'h0);
      chk("bubble_if_valid", {31'd0, if_valid}, 32'd0);
    end
    cyc(0, 0, 32'h0, 1, W2B, 1, 32'h8, 1, W2B, 32'h8);
    cyc(0, 0, 32'h0, 1, W3, 1, 32'hC, 1, W3, 32'hC);

    // HALT at 16: delivered once, held under stall, redirect ignored afterwards
    cyc(0, 0, 32'h0, 1, HALT, 1, 32'h10, 1, HALT, 32'h10);
    chk("halted_set", {31'd0, halted}, 32'd1);
    cyc(1, 0, 32'h0, 1, W0, 0, 32'h10, 1, HALT, 32'h10);
    cyc(0, 0, 32'h0, 1, W0, 0, 32'h10, 0, NOP, 32'h0);
    chk("halt_valid_drop", {31'd0, if_valid}, 32'd0);
    cyc(0, 1, 32'h0000_0100, 1, W0, 0, 32'h10, 0, NOP, 32'h0);
    cyc(0, 0, 32'h0, 1, W0, 0, 32'h10, 0, NOP, 32'h0);
    chk("halted_stays", {31'd0, halted}, 32'd1);
    chk("halted_no_valid", {31'd0, if_valid}, 32'd0);

    // Reset out of HALTED
    rst = 1'b1;
    #1;
    chk("req_in_reset2", {31'd0, imem_req}, 32'd0);
    @(posedge clk);
    #1;
    chk_reset_state();
    rst = 1'b0;

    // PC wrap at the top of the address space (low redirect bits ignored)
    cyc(0, 1, 32'hFFFF_FFFF, 1, W0, 1, 32'h0, 0, NOP, 32'h0);
    cyc(0, 0, 32'h0, 1, W5, 1, 32'hFFFF_FFFC, 1, W5, 32'hFFFF_FFFC);
    chk("wrap_pc_plus4", pc_plus4, 32'h0);
    cyc(0, 0, 32'h0, 0, W0, 1, 32'h0, 0, NOP, 32'h0);

    @(negedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
